modinv_helper_reduce_precalc_multi: RTL and testbench

Multi-mode precalculation helper for the modular inverter's reduction step. It computes, in two word-serial passes over the working buffers, r = s ± q, u = s >> 1 and v = r >> 1. It also produces the status flags the inverter FSM branches on. It sits between the inverter controller and its s/q/r/u/v block memories, replacing the add-only fixed-32-bit precalc helper with a width-parametrised add/subtract version that also reports extra result flags.

---
 rtl/modinv_helper_reduce_precalc_multi_if.sv | 45 ++++
 rtl/modinv_helper_reduce_precalc_multi.sv | 205 ++++++++++++++++++++
 tb/tb_modinv_helper_reduce_precalc_multi.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modinv_helper_reduce_precalc_multi_if.sv
// Controller-side bus of the reduce precalc helper: start handshake, status
// flags and the s/q/r/u/v block-memory ports.
interface modinv_helper_reduce_precalc_multi_if #(
    parameter int OPERAND_ADDR_BITS = 3,
    parameter int BUFFER_ADDR_BITS  = 4,
    parameter int K_NUM_BITS        = 10,
    parameter int WORD_BITS         = 32
);
    logic                         ena;
    logic                         rdy;
    logic                         mode_sub;
    logic [K_NUM_BITS-1:0]        k;
    logic                         s_is_odd;
    logic                         k_is_nul;
    logic                         r_is_zero;
    logic                         r_carry;
    logic [BUFFER_ADDR_BITS-1:0]  s_addr;
    logic [WORD_BITS-1:0]         s_din;
    logic [OPERAND_ADDR_BITS-1:0] q_addr;
    logic [WORD_BITS-1:0]         q_din;
    logic [BUFFER_ADDR_BITS-1:0]  r_addr;
    logic [WORD_BITS-1:0]         r_din;
    logic                         r_wren;
    logic [WORD_BITS-1:0]         r_dout;
    logic [BUFFER_ADDR_BITS-1:0]  u_addr;
    logic                         u_wren;
    logic [WORD_BITS-1:0]         u_dout;
    logic [BUFFER_ADDR_BITS-1:0]  v_addr;
    logic                         v_wren;
    logic [WORD_BITS-1:0]         v_dout;

    modport master (
        output ena, mode_sub, k, s_din, q_din, r_din,
        input  rdy, s_is_odd, k_is_nul, r_is_zero, r_carry,
        input  s_addr, q_addr, r_addr, r_wren, r_dout,
        input  u_addr, u_wren, u_dout, v_addr, v_wren, v_dout
    );

    modport slave (
        input  ena, mode_sub, k, s_din, q_din, r_din,
        output rdy, s_is_odd, k_is_nul, r_is_zero, r_carry,
        output s_addr, q_addr, r_addr, r_wren, r_dout,
        output u_addr, u_wren, u_dout, v_addr, v_wren, v_dout
    );
endinterface

// File: rtl/modinv_helper_reduce_precalc_multi.sv
// Reduce-step precalc for the modular inverter: forward pass r = s +/- q,
// backward pass u = s >> 1, v = r >> 1, plus branch flags for the controller.
module modinv_helper_reduce_precalc_multi #(
    parameter int OPERAND_NUM_WORDS = 8,
    parameter int OPERAND_ADDR_BITS = 3,
    parameter int BUFFER_NUM_WORDS  = 9,
    parameter int BUFFER_ADDR_BITS  = 4,
    parameter int K_NUM_BITS        = 10,
    parameter int WORD_BITS         = 32
) (
    input logic clk,
    input logic rst,
    modinv_helper_reduce_precalc_multi_if.slave bus
);
    localparam int N        = BUFFER_NUM_WORDS;
    localparam int W        = WORD_BITS;
    localparam int CNT_BITS = $clog2(2 * N + 4);

    typedef logic [CNT_BITS-1:0]          cnt_t;
    typedef logic [BUFFER_ADDR_BITS-1:0]  baddr_t;
    typedef logic [OPERAND_ADDR_BITS-1:0] qaddr_t;
    typedef logic [W-1:0]                 word_t;
    typedef logic [K_NUM_BITS-1:0]        k_t;
    typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;

    // cnt_q holds the index of the edge being computed, counted from accept = 0
    localparam cnt_t FWD_LAST_RD = cnt_t'(N - 1);
    localparam cnt_t FWD_LAST_WR = cnt_t'(N + 1);
    localparam cnt_t TURN        = cnt_t'(N + 2);
    localparam cnt_t BWD_LAST_RD = cnt_t'(2 * N + 1);
    localparam cnt_t BWD_LAST_UV = cnt_t'(2 * N + 2);
    localparam cnt_t DONE        = cnt_t'(2 * N + 3);

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   rdy_q, rdy_d;
    logic   mode_q, mode_d;
    logic   carry_q, carry_d;
    logic   s_is_odd_q, s_is_odd_d;
    logic   k_is_nul_q, k_is_nul_d;
    logic   r_is_zero_q, r_is_zero_d;
    logic   r_carry_q, r_carry_d;
    baddr_t s_addr_q, s_addr_d;
    qaddr_t q_addr_q, q_addr_d;
    baddr_t r_addr_q, r_addr_d;
    logic   r_wren_q, r_wren_d;
    word_t  r_dout_q, r_dout_d;
    baddr_t uv_addr_q, uv_addr_d;
    logic   uv_wren_q, uv_wren_d;
    logic   s_lsb_q, s_lsb_d;
    logic   r_lsb_q, r_lsb_d;
    word_t  q_word;
    logic [W:0] sum;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + cnt_t'(1);
        rdy_d       = rdy_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        s_is_odd_d  = s_is_odd_q;
        k_is_nul_d  = k_is_nul_q;
        r_is_zero_d = r_is_zero_q;
        r_carry_d   = r_carry_q;
        s_addr_d    = s_addr_q;
        q_addr_d    = q_addr_q;
        r_addr_d    = r_addr_q;
        r_wren_d    = 1'b0;
        r_dout_d    = r_dout_q;
        uv_addr_d   = uv_addr_q;
        uv_wren_d   = 1'b0;
        s_lsb_d     = s_lsb_q;
        r_lsb_d     = r_lsb_q;
        q_word      = '0;
        sum         = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.ena) begin
                    state_d     = FWD;
                    cnt_d       = cnt_t'(1);
                    rdy_d       = 1'b0;
                    mode_d      = bus.mode_sub;
                    carry_d     = bus.mode_sub;
                    k_is_nul_d  = (bus.k == k_t'(0));
                    s_is_odd_d  = 1'b0;
                    r_is_zero_d = 1'b1;
                    r_carry_d   = 1'b0;
                    s_addr_d    = '0;
                    q_addr_d    = '0;
                end
            end

            FWD: begin
                if (cnt_q <= FWD_LAST_RD) begin
                    s_addr_d = baddr_t'(cnt_q);
                    q_addr_d = (cnt_q < cnt_t'(OPERAND_NUM_WORDS)) ? qaddr_t'(cnt_q) : '0;
                end
                // words above the operand width read q[0]; the data is masked here
                if (cnt_q >= cnt_t'(2) && cnt_q <= FWD_LAST_WR) begin
                    q_word = (cnt_q < cnt_t'(OPERAND_NUM_WORDS + 2)) ? bus.q_din : '0;
                    if (mode_q) q_word = ~q_word;
                    sum         = {1'b0, bus.s_din} + {1'b0, q_word} + {{W{1'b0}}, carry_q};
                    r_dout_d    = sum[W-1:0];
                    carry_d     = sum[W];
                    r_wren_d    = 1'b1;
                    r_addr_d    = baddr_t'(cnt_q - cnt_t'(2));
                    r_is_zero_d = r_is_zero_q & (sum[W-1:0] == '0);
                    if (cnt_q == cnt_t'(2)) s_is_odd_d = bus.s_din[0];
                    if (cnt_q == FWD_LAST_WR) r_carry_d = sum[W] ^ mode_q;
                end
                if (cnt_q == TURN) begin
                    state_d  = BWD;
                    s_addr_d = baddr_t'(N - 1);
                    r_addr_d = baddr_t'(N - 1);
                    s_lsb_d  = 1'b0;
                    // a negative difference shifts in its sign
                    r_lsb_d  = mode_q & r_carry_q;
                end
            end

            BWD: begin
                if (cnt_q <= BWD_LAST_RD) begin
                    s_addr_d = s_addr_q - baddr_t'(1);
                    r_addr_d = s_addr_q - baddr_t'(1);
                end
                if (cnt_q <= BWD_LAST_UV) begin
                    uv_wren_d = 1'b1;
                    uv_addr_d = s_addr_q;
                end
                if (uv_wren_q) begin
                    s_lsb_d = bus.s_din[0];
                    r_lsb_d = bus.r_din[0];
                end
                if (cnt_q == DONE) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b1;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            s_is_odd_q  <= 1'b0;
            k_is_nul_q  <= 1'b0;
            r_is_zero_q <= 1'b0;
            r_carry_q   <= 1'b0;
            s_addr_q    <= '0;
            q_addr_q    <= '0;
            r_addr_q    <= '0;
            r_wren_q    <= 1'b0;
            r_dout_q    <= '0;
            uv_addr_q   <= '0;
            uv_wren_q   <= 1'b0;
            s_lsb_q     <= 1'b0;
            r_lsb_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            s_is_odd_q  <= s_is_odd_d;
            k_is_nul_q  <= k_is_nul_d;
            r_is_zero_q <= r_is_zero_d;
            r_carry_q   <= r_carry_d;
            s_addr_q    <= s_addr_d;
            q_addr_q    <= q_addr_d;
            r_addr_q    <= r_addr_d;
            r_wren_q    <= r_wren_d;
            r_dout_q    <= r_dout_d;
            uv_addr_q   <= uv_addr_d;
            uv_wren_q   <= uv_wren_d;
            s_lsb_q     <= s_lsb_d;
            r_lsb_q     <= r_lsb_d;
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.s_is_odd  = s_is_odd_q;
    assign bus.k_is_nul  = k_is_nul_q;
    assign bus.r_is_zero = r_is_zero_q;
    assign bus.r_carry   = r_carry_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.q_addr    = q_addr_q;
    assign bus.r_addr    = r_addr_q;
    assign bus.r_wren    = r_wren_q;
    assign bus.r_dout    = r_dout_q;
    assign bus.u_addr    = uv_addr_q;
    assign bus.u_wren    = uv_wren_q;
    assign bus.v_addr    = uv_addr_q;
    assign bus.v_wren    = uv_wren_q;
    // shifted words leave straight from read data so each write lands the cycle it arrives
    assign bus.u_dout    = {s_lsb_q, bus.s_din[W-1:1]};
    assign bus.v_dout    = {r_lsb_q, bus.r_din[W-1:1]};
endmodule

// File: tb/tb_modinv_helper_reduce_precalc_multi.sv
// Scoreboard bench: each scenario queues its expected writes and completion
// flags; a negedge monitor pops and compares as the DUT produces them.
module tb_modinv_helper_reduce_precalc_multi;
    localparam int N   = 9;
    localparam int OPW = 8;
    localparam int W   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modinv_helper_reduce_precalc_multi_if #(
        .OPERAND_ADDR_BITS(3), .BUFFER_ADDR_BITS(4), .K_NUM_BITS(10), .WORD_BITS(W)
    ) bus ();

    modinv_helper_reduce_precalc_multi #(
        .OPERAND_NUM_WORDS(OPW), .OPERAND_ADDR_BITS(3), .BUFFER_NUM_WORDS(N),
        .BUFFER_ADDR_BITS(4), .K_NUM_BITS(10), .WORD_BITS(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [W-1:0] s_mem [N];
    logic [W-1:0] q_mem [OPW];
    logic [W-1:0] r_mem [N];

    always @(posedge clk) begin
        bus.s_din <= s_mem[bus.s_addr];
        bus.q_din <= q_mem[bus.q_addr];
        bus.r_din <= r_mem[bus.r_addr];
        if (bus.r_wren) r_mem[bus.r_addr] <= bus.r_dout;
    end

    typedef struct { int cyc; int addr; logic [W-1:0] data; } wr_t;
    typedef struct { int cyc; int busy; logic odd; logic nul; logic zero; logic carry; } done_t;

    wr_t   exp_r[$], exp_u[$], exp_v[$];
    done_t exp_d[$];
    logic [W-1:0] er [N];
    logic [W-1:0] eu [N];
    logic [W-1:0] ev [N];
    int tests = 0;
    int fails = 0;

    task automatic clear_exp();
        for (int i = 0; i < N; i++) begin
            er[i] = '0; eu[i] = '0; ev[i] = '0;
        end
    endtask

    task automatic load(input logic [W-1:0] s0, input logic [W-1:0] q0, input logic qfill);
        for (int i = 0; i < N; i++) s_mem[i] = '0;
        for (int i = 0; i < OPW; i++) q_mem[i] = qfill ? 32'hFFFF_FFFF : 32'h0;
        s_mem[0] = s0;
        if (!qfill) q_mem[0] = q0;
    endtask

    task automatic push_r(input int count);
        wr_t w;
        for (int i = 0; i < count; i++) begin
            w.cyc = i + 3; w.addr = i; w.data = er[i];
            exp_r.push_back(w);
        end
    endtask

    task automatic push_uv();
        wr_t w;
        for (int i = N - 1; i >= 0; i--) begin
            w.cyc = 2 * N + 3 - i; w.addr = i;
            w.data = eu[i]; exp_u.push_back(w);
            w.data = ev[i]; exp_v.push_back(w);
        end
    endtask

    task automatic push_done(input int cyc, input int busy, input logic odd,
                             input logic nul, input logic zero, input logic carry);
        done_t d;
        d.cyc = cyc; d.busy = busy; d.odd = odd; d.nul = nul; d.zero = zero; d.carry = carry;
        exp_d.push_back(d);
    endtask

    task automatic push_pass(input logic odd, input logic nul, input logic zero, input logic carry);
        push_r(N);
        push_uv();
        push_done(2 * N + 4, 2 * N + 3, odd, nul, zero, carry);
    endtask

    task automatic start(input logic m, input logic [9:0] kk);
        int t;
        t = 0;
        while (!bus.rdy && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!bus.rdy) begin
            tests++; fails++;
            $display("FAIL start_timeout rdy=%0b required 1", bus.rdy);
        end
        bus.ena = 1'b1; bus.mode_sub = m; bus.k = kk;
        @(posedge clk); #1;
        bus.ena = 1'b0; bus.mode_sub = ~m; bus.k = ~kk;
    endtask

    task automatic drain(input string name);
        tests++;
        if (exp_r.size() != 0 || exp_u.size() != 0 || exp_v.size() != 0 || exp_d.size() != 0) begin
            fails++;
            $display("FAIL drain_%s left r=%0d u=%0d v=%0d done=%0d, required all 0",
                     name, exp_r.size(), exp_u.size(), exp_v.size(), exp_d.size());
        end
    endtask

    task automatic run_pass(input string name, input logic m, input logic [9:0] kk);
        start(m, kk);
        repeat (2 * N + 6) @(posedge clk);
        #1;
        drain(name);
    endtask

    // monitor: now = cycle number of the current negedge, cycle 1 follows the accept edge
    int   now = 0;
    int   busy = 0;
    logic acc_pend = 1'b0;
    logic prev_rdy = 1'b1;

    task automatic chk_wr(input string name, input wr_t e, input int a, input logic [W-1:0] d);
        tests++;
        if (e.cyc != now || e.addr != a || e.data !== d) begin
            fails++;
            $display("FAIL %s got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                     name, now, a, d, e.cyc, e.addr, e.data);
        end
    endtask

    always @(negedge clk) begin
        wr_t   e;
        done_t d;
        if (acc_pend) begin now = 1; busy = 0; end
        else now++;
        if (!bus.rdy) busy++;
        if (bus.r_wren) begin
            if (exp_r.size() == 0) begin e.cyc = -1; e.addr = -1; e.data = '0; end
            else e = exp_r.pop_front();
            chk_wr("r_write", e, int'(bus.r_addr), bus.r_dout);
        end
        if (bus.u_wren) begin
            if (exp_u.size() == 0) begin e.cyc = -1; e.addr = -1; e.data = '0; end
            else e = exp_u.pop_front();
            chk_wr("u_write", e, int'(bus.u_addr), bus.u_dout);
        end
        if (bus.v_wren) begin
            if (exp_v.size() == 0) begin e.cyc = -1; e.addr = -1; e.data = '0; end
            else e = exp_v.pop_front();
            chk_wr("v_write", e, int'(bus.v_addr), bus.v_dout);
        end
        if (bus.rdy && !prev_rdy) begin
            if (exp_d.size() == 0) begin
                d.cyc = -1; d.busy = -1; d.odd = 0; d.nul = 0; d.zero = 0; d.carry = 0;
            end else d = exp_d.pop_front();
            tests++;
            if (d.cyc != now || d.busy != busy || d.odd !== bus.s_is_odd || d.nul !== bus.k_is_nul ||
                d.zero !== bus.r_is_zero || d.carry !== bus.r_carry) begin
                fails++;
                $display("FAIL done got cyc=%0d busy=%0d odd=%0b nul=%0b zero=%0b carry=%0b, required cyc=%0d busy=%0d odd=%0b nul=%0b zero=%0b carry=%0b",
                         now, busy, bus.s_is_odd, bus.k_is_nul, bus.r_is_zero, bus.r_carry,
                         d.cyc, d.busy, d.odd, d.nul, d.zero, d.carry);
            end
        end
        prev_rdy = bus.rdy;
        acc_pend = bus.ena && bus.rdy && !rst;
    end

    initial begin
        rst = 1'b1;
        bus.ena = 1'b0; bus.mode_sub = 1'b0; bus.k = '0;
        for (int i = 0; i < N; i++) r_mem[i] = '0;
        load(32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 bus.ena = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.rdy !== 1'b1 || bus.r_wren !== 1'b0 || bus.u_wren !== 1'b0 || bus.v_wren !== 1'b0 ||
            bus.s_addr !== '0 || bus.q_addr !== '0 || bus.r_addr !== '0 || bus.u_addr !== '0 ||
            bus.v_addr !== '0 || bus.s_is_odd !== 1'b0 || bus.k_is_nul !== 1'b0 ||
            bus.r_is_zero !== 1'b0 || bus.r_carry !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got rdy=%0b wren=%0b%0b%0b flags=%0b%0b%0b%0b, required rdy=1 wren=000 flags=0000",
                     bus.rdy, bus.r_wren, bus.u_wren, bus.v_wren,
                     bus.s_is_odd, bus.k_is_nul, bus.r_is_zero, bus.r_carry);
        end
        rst = 1'b0; bus.ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drain("reset");

        // add with full carry ripple: 1 + (2^256 - 1) = 2^256
        load(32'h1, 32'h0, 1'b1);
        clear_exp(); er[8] = 32'h1; ev[7] = 32'h8000_0000;
        push_pass(1'b1, 1'b0, 1'b0, 1'b0);
        run_pass("add_ripple", 1'b0, 10'd5);

        // 5 - 3 = 2
        load(32'h5, 32'h3, 1'b0);
        clear_exp(); er[0] = 32'h2; eu[0] = 32'h2; ev[0] = 32'h1;
        push_pass(1'b1, 1'b0, 1'b0, 1'b0);
        run_pass("sub_pos", 1'b1, 10'd7);

        // 3 - 5 = -2, arithmetic shift gives -1
        load(32'h3, 32'h5, 1'b0);
        clear_exp();
        for (int i = 0; i < N; i++) begin er[i] = 32'hFFFF_FFFF; ev[i] = 32'hFFFF_FFFF; end
        er[0] = 32'hFFFF_FFFE; eu[0] = 32'h1;
        push_pass(1'b1, 1'b0, 1'b0, 1'b1);
        run_pass("sub_neg", 1'b1, 10'd3);

        // all zero, k = 0
        load(32'h0, 32'h0, 1'b0);
        clear_exp();
        push_pass(1'b0, 1'b1, 1'b1, 1'b0);
        run_pass("zero", 1'b0, 10'd0);

        // ena at cycle 7 ignored, rst at cycle 10 aborts after eight r writes
        load(32'h1, 32'h0, 1'b1);
        clear_exp();
        push_r(8);
        push_done(11, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        start(1'b0, 10'd5);
        repeat (6) @(posedge clk);
        #1 bus.ena = 1'b1;
        @(posedge clk);
        #1 bus.ena = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drain("abort");

        // clean restart after abort reproduces the add result
        clear_exp(); er[8] = 32'h1; ev[7] = 32'h8000_0000;
        push_pass(1'b1, 1'b0, 1'b0, 1'b0);
        run_pass("restart", 1'b0, 10'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
